// File: rtl/step_pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// step_pulse_gen_pkg
// Shared kit definitions for the step pulse generator: repeat FSM state
// encoding, default timing constants and a width helper used to size counters.
// -----------------------------------------------------------------------------
package step_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 20000;
  localparam int unsigned DEF_REPEAT_DELAY    = 10000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  // Bits needed to hold max_val (at least one bit, so a zero max still
  // yields a legal vector).
  function automatic int unsigned width_for(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a counting debouncer. The debounced level
// follows the synchronised button only after DEBOUNCE_CYCLES consecutive
// mismatching samples, so a clean change shows up DEBOUNCE_CYCLES+2 edges
// after it happens on btn.
//
// Ports
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   btn    : raw asynchronous, bouncing push button (active high)
//   btn_db : debounced button level
// -----------------------------------------------------------------------------
module btn_debounce
  import step_pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_db
);

  localparam int unsigned CW = width_for(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_s1;
  logic          btn_s;
  logic [CW-1:0] cnt;

  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values; blocking assignments would collapse the synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s  <= 1'b0;
      btn_db <= 1'b0;
      cnt    <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s  <= btn_s1;
      if (btn_s == btn_db) begin
        // Any agreeing sample restarts the stability count.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_db <= btn_s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// -----------------------------------------------------------------------------
// step_pulse_gen
// Turns a bouncing push button into single-cycle STEP pulses: one pulse per
// accepted press, plus optional auto-repeat (first repeat REPEAT_DELAY cycles
// after the press pulse, then every REPEAT_PERIOD cycles) while held.
//
// Ports
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   btn       : raw asynchronous, bouncing push button (active high)
//   repeat_en : 1 enables auto-repeat while the button is held
//   btn_db    : debounced button level
//   step      : one-cycle-high pulse per accepted step
// -----------------------------------------------------------------------------
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic repeat_en,
  output logic btn_db,
  output logic step
);

  localparam int unsigned TMAX = ((REPEAT_DELAY > REPEAT_PERIOD) ?
                                  REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int unsigned TW = width_for(TMAX);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  state_t        state;
  logic [TW-1:0] timer;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .btn_db(btn_db)
  );

  // The timer saturates at its terminal value while a pulse is held off, so
  // it never exceeds max(REPEAT_DELAY, REPEAT_PERIOD)-1. A due pulse is
  // deferred one cycle when step is already high, which keeps at least one
  // low cycle between pulses even for a period or delay of 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      step  <= 1'b0;
    end else begin
      step <= 1'b0;
      if (!btn_db) begin
        // Release wins over any pulse due on this edge.
        state <= IDLE;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            // Only reachable with btn_db high right after a rising edge.
            state <= DELAY;
            timer <= '0;
            step  <= 1'b1;
          end
          DELAY: begin
            if (repeat_en) begin
              if (timer == DELAY_LAST) begin
                if (!step) begin
                  step  <= 1'b1;
                  timer <= '0;
                  state <= REPEAT;
                end
              end else begin
                timer <= timer + TW'(1);
              end
            end
          end
          REPEAT: begin
            if (!repeat_en) begin
              state <= DELAY;
              timer <= '0;
            end else if (timer == PERIOD_LAST) begin
              if (!step) begin
                step  <= 1'b1;
                timer <= '0;
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_step_pulse_gen
// Directed bench for step_pulse_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. A behavioural model (delay queue, sample window, countdown
// scheduler) is compared against btn_db and step on every falling clock edge;
// directed scenarios add hand-computed timing expectations.
// -----------------------------------------------------------------------------
module tb_step_pulse_gen;
  import step_pulse_gen_pkg::*;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic btn       = 1'b0;
  logic repeat_en = 1'b0;
  logic btn_db;
  logic step;

  step_pulse_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .repeat_en(repeat_en),
    .btn_db   (btn_db),
    .step     (step)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;   // number of rising edges so far

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit gated_q[$] = '{1'b0, 1'b0};  // btn as seen at each edge, 0 while in reset
  bit s_hist[$];                   // last DB synchronised samples
  bit m_db   = 1'b0;
  bit m_step = 1'b0;
  int m_mode = 0;                  // 0 idle, 1 waiting first repeat, 2 repeating
  int m_left = 0;                  // enabled edges left until the next pulse

  always @(posedge clk) begin : model
    bit bs;
    bit nstep;
    bit all_diff;
    cyc++;
    if (rst) begin
      gated_q.push_back(1'b0);
      s_hist.delete();
      m_db   = 1'b0;
      m_step = 1'b0;
      m_mode = 0;
      m_left = 0;
    end else begin
      bs = gated_q[gated_q.size() - 2];  // btn two edges back
      gated_q.push_back(btn);
      nstep = 1'b0;
      if (!m_db) begin
        m_mode = 0;
        m_left = 0;
      end else begin
        case (m_mode)
          0: begin
            m_mode = 1;
            m_left = RD;
            nstep  = 1'b1;
          end
          1: if (repeat_en) begin
            if (m_left == 1) begin
              if (!m_step) begin
                nstep  = 1'b1;
                m_mode = 2;
                m_left = RP;
              end
            end else m_left--;
          end
          default: begin
            if (!repeat_en) begin
              m_mode = 1;
              m_left = RD;
            end else if (m_left == 1) begin
              if (!m_step) begin
                nstep  = 1'b1;
                m_left = RP;
              end
            end else m_left--;
          end
        endcase
      end
      m_step = nstep;
      s_hist.push_back(bs);
      if (s_hist.size() > DB) void'(s_hist.pop_front());
      if (s_hist.size() == DB) begin
        all_diff = 1'b1;
        foreach (s_hist[i]) if (s_hist[i] == m_db) all_diff = 1'b0;
        if (all_diff) m_db = !m_db;
      end
    end
    if (gated_q.size() > 4) void'(gated_q.pop_front());
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare and event logging
  // ---------------------------------------------------------------------------
  int step_q[$];        // edge numbers at which step went high
  int db_rise_cyc = -1;
  int n_rise      = 0;
  bit db_prev     = 1'b0;

  always @(negedge clk) begin
    check("btn_db_vs_model", btn_db, m_db);
    check("step_vs_model", step, m_step);
    if (step === 1'b1) step_q.push_back(cyc);
    if (btn_db === 1'b1 && !db_prev) begin
      db_rise_cyc = cyc;
      n_rise++;
    end
    db_prev = (btn_db === 1'b1);
  end

  // Attached modulo-5 counter advancing on the falling edge of step.
  logic b5_rst = 1'b1;
  int   b5     = 0;
  always @(negedge step or posedge b5_rst) begin
    if (b5_rst) b5 <= 0;
    else        b5 <= (b5 + 1) % 5;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int step_at(input int idx);
    return (idx < step_q.size()) ? step_q[idx] : -1;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  int c, base, last, rel, r;
  int rise0;
  int exp_off[6] = '{7, 17, 20, 23, 26, 29};

  initial begin
    tick(3);
    check("reset_btn_db", btn_db, 0);
    check("reset_step", step, 0);
    check("reset_state", int'(dut.state), int'(IDLE));
    check("reset_timer", int'(dut.timer), 0);
    rst = 1'b0;
    b5_rst = 1'b0;
    tick(5);

    // Clean press, no repeat.
    base = step_q.size(); c = cyc; rise0 = n_rise;
    btn = 1'b1;
    tick(40);
    check("clean_db_latency", db_rise_cyc - c, 6);
    check("clean_step_count", step_q.size() - base, 1);
    check("clean_step_latency", step_at(base) - c, 7);
    check("clean_state_delay", int'(dut.state), int'(DELAY));
    btn = 1'b0;
    tick(12);
    check("clean_release_idle", int'(dut.state), int'(IDLE));

    // Bounce with widths 1,2,3 then stable high.
    base = step_q.size(); rise0 = n_rise;
    btn = 1'b1; tick(1); btn = 1'b0; tick(1);
    btn = 1'b1; tick(2); btn = 1'b0; tick(2);
    btn = 1'b1; tick(3); btn = 1'b0; tick(3);
    last = cyc;
    btn = 1'b1;
    tick(20);
    check("bounce_rise_count", n_rise - rise0, 1);
    check("bounce_db_latency", db_rise_cyc - last, 6);
    check("bounce_step_count", step_q.size() - base, 1);
    btn = 1'b0;
    tick(12);

    // Auto-repeat with attached counter.
    b5_rst = 1'b1; tick(1); b5_rst = 1'b0;
    repeat_en = 1'b1;
    base = step_q.size(); c = cyc;
    btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      for (int k = 0; k < 6; k++)
        if (cyc == c + exp_off[k] + 1) check("b5_value", b5, (k + 1) % 5);
    end
    for (int k = 0; k < 6; k++) check("repeat_step_time", step_at(base + k) - c, exp_off[k]);
    btn = 1'b0; repeat_en = 1'b0;
    tick(12);

    // Release so that btn_db is low on the edge a repeat pulse is due.
    repeat_en = 1'b1;
    base = step_q.size(); c = cyc;
    btn = 1'b1;
    tick(19);
    btn = 1'b0;
    tick(6);
    check("due_db_fell", btn_db, 0);
    tick(1);
    check("due_no_step", step, 0);
    check("due_state_idle", int'(dut.state), int'(IDLE));
    check("due_timer_zero", int'(dut.timer), 0);
    check("due_step_count", step_q.size() - base, 4);
    repeat_en = 1'b0;
    tick(10);

    // Drop repeat_en while repeating, then raise it again.
    repeat_en = 1'b1;
    base = step_q.size(); c = cyc;
    btn = 1'b1;
    tick(21);
    repeat_en = 1'b0;
    tick(15);
    check("drop_step_count", step_q.size() - base, 3);
    check("drop_state_delay", int'(dut.state), int'(DELAY));
    r = cyc; base = step_q.size();
    repeat_en = 1'b1;
    tick(14);
    check("raise_next_step", step_at(base) - r, 10);

    // Reset for two cycles while repeating, button still held.
    rst = 1'b1; repeat_en = 1'b0;
    tick(1);
    check("rst_hold_db", btn_db, 0);
    check("rst_hold_step", step, 0);
    tick(1);
    check("rst_hold_state", int'(dut.state), int'(IDLE));
    rst = 1'b0;
    rel = cyc; base = step_q.size();
    tick(20);
    check("rst_step_count", step_q.size() - base, 1);
    check("rst_step_latency", step_at(base) - rel, 7);
    btn = 1'b0;
    tick(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20000, which is the number of consecutive stable samples required to accept a BTN change (range 1..2^20).
REQ-002 SHALL have parameter REPEAT_DELAY, default 10000000, which is the number of cycles from an accepted press to the first auto-repeat STEP (range ≥1).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, which is the number of cycles between subsequent auto-repeat STEPs (range ≥1).
REQ-004 SHALL have port CLK, input, 1 bit: the single system clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port BTN, input, 1 bit: raw asynchronous push button, active-high, bouncing.
REQ-007 SHALL have port REPEAT_EN, input, 1 bit: 1 enables auto-repeat while the button is held.
REQ-008 SHALL have port BTN_DB, output, 1 bit: the debounced button level.
REQ-009 SHALL have port STEP, output, 1 bit: a one-cycle-high pulse per accepted step, which directly drives the b5_counter CLK input (its falling edge advances the counter).

Function
REQ-010 SHALL synchronise BTN through two flip-flops (BTN_S = second stage) before any other use.
REQ-011 SHALL clear the debounce counter on every edge where BTN_S == BTN_DB, and increment it otherwise.
REQ-012 SHALL set BTN_DB to BTN_S on the DEBOUNCE_CYCLES-th consecutive mismatching edge and clear the counter on that edge, so that a clean BTN change appears on BTN_DB exactly DEBOUNCE_CYCLES+2 edges later.
REQ-013 SHALL discard any glitch shorter than DEBOUNCE_CYCLES cycles at BTN_S without changing BTN_DB.
REQ-014 SHALL implement the repeat FSM with the states IDLE, DELAY and REPEAT, plus a shared timer.
REQ-015 SHALL, in IDLE, move to DELAY when BTN_DB rises, assert STEP on the next cycle, and clear the timer.
REQ-016 SHALL, in DELAY with REPEAT_EN=1, increment the timer; when the timer reaches REPEAT_DELAY-1 it SHALL pulse STEP, clear the timer and enter REPEAT.
REQ-017 SHALL, in DELAY with REPEAT_EN=0, hold the timer and remain in DELAY, with no further STEPs.
REQ-018 SHALL, in REPEAT, pulse STEP each time the timer reaches REPEAT_PERIOD-1 and then clear the timer; if REPEAT_EN=0, it SHALL return to DELAY with the timer cleared.
REQ-019 SHALL, when BTN_DB=0 in any state, go to IDLE with the timer cleared and no STEP, even if a pulse was due on the same edge (release wins).
REQ-020 SHALL keep STEP high for exactly one cycle, so two STEPs are always separated by ≥1 low cycle, even with REPEAT_PERIOD=1 (in which case STEPs occur every 2 cycles).
REQ-021 SHALL never generate a STEP from a BTN_DB falling edge.
REQ-022 SHALL size the timer to hold max(REPEAT_DELAY, REPEAT_PERIOD)-1, with no wrap-around.

Reset
REQ-023 SHALL, while RST=1, force the sync flip-flops, BTN_DB, STEP, the debounce counter and the timer to 0, and the FSM to IDLE.
REQ-024 SHALL, if the button is held across reset release, accept it as a new press after DEBOUNCE_CYCLES+2 edges and emit exactly one STEP.
REQ-025 SHALL drop a STEP pending at the time of a reset assertion mid-operation.

Structure
REQ-026 SHALL take its FSM state encoding (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2) and its default timing constants from the shared kit package/include.
REQ-027 SHALL place the synchroniser and debounce logic in sub-module btn_debounce (ports CLK, RST, BTN, BTN_DB); step_pulse_gen SHALL instantiate it and add the FSM.

Verification (bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-028 SHALL cover clean press: BTN 0→1 held 40 cycles, REPEAT_EN=0 -> BTN_DB rises 6 edges after the change, one STEP on the next cycle, and no more STEPs.
REQ-029 SHALL cover bounce: BTN toggling with high/low widths 1,2,3 cycles, then stable high -> BTN_DB rises once, 6 edges after the last toggle, and exactly one STEP.
REQ-030 SHALL cover auto-repeat: hold BTN with REPEAT_EN=1 -> STEPs at press+1, +10 and then every 3 cycles; an attached b5_counter reads 0,1,2,3,4,0,...
REQ-031 SHALL cover release during REPEAT: BTN_DB falls on the edge a STEP is due -> no STEP, FSM in IDLE, timer 0.
REQ-032 SHALL cover REPEAT_EN dropped in REPEAT: -> STEPs stop, FSM in DELAY; raising REPEAT_EN -> the next STEP comes 10 cycles later.
REQ-033 SHALL cover reset mid-hold: RST=1 for 2 cycles during REPEAT -> all outputs 0 during reset; with BTN still high, one STEP follows 6 edges plus 1 cycle after release.
